// File: rtl/fir_stream_pkg.sv
// rtl/fir_stream_pkg.sv - shared types and defaults for the FIR sample streamer
package fir_stream_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    typedef logic signed [DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_sample_streamer_if.sv
// rtl/fir_sample_streamer_if.sv - host/filter bus of the sample streamer
// master: host side (drives wr_en, wr_data, start; observes status and stream)
// slave : streamer side (drives full, overflow, busy, done, output_signal,
//         valid_out, sample_count)
interface fir_sample_streamer_if #(
    parameter int DATA_W = fir_stream_pkg::DATA_W,
    parameter int DEPTH  = 2048
);

    logic                      wr_en;
    logic signed [DATA_W-1:0]  wr_data;
    logic                      start;
    logic                      full;
    logic                      overflow;
    logic                      busy;
    logic                      done;
    logic signed [DATA_W-1:0]  output_signal;
    logic                      valid_out;
    logic [$clog2(DEPTH):0]    sample_count;

    modport master (
        output wr_en, wr_data, start,
        input  full, overflow, busy, done, output_signal, valid_out, sample_count
    );

    modport slave (
        input  wr_en, wr_data, start,
        output full, overflow, busy, done, output_signal, valid_out, sample_count
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read
// clk, rst     : clock, synchronous active-high reset
// push, din    : enqueue din; ignored while full
// pop          : dequeue; ignored while empty
// dout         : popped word for the cycle after a pop, zero otherwise
// empty, full  : registered occupancy flags
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2048
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Flags are registered from count_next so they are valid the cycle after
    // the push/pop that changed them. dout is zeroed on non-pop cycles so the
    // streamer can drive it straight out as a gap-free-of-stale-data sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            dout  <= do_pop ? mem[rd_ptr] : '0;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == FULL_CNT);
        end
    end

endmodule

// File: rtl/fir_sample_streamer.sv
// rtl/fir_sample_streamer.sv - buffered sample source feeding the FIR filter
// clk, rst : clock, synchronous active-high reset
// bus      : slave side of fir_sample_streamer_if
//            wr_en/wr_data load the FIFO, start begins a run,
//            output_signal/valid_out carry samples then FLUSH_LEN zeros,
//            done pulses at the end, busy while a run is active,
//            full/overflow report FIFO state, sample_count counts emitted data
module fir_sample_streamer #(
    parameter int DATA_W    = fir_stream_pkg::DATA_W,
    parameter int DEPTH     = 2048,
    parameter int FLUSH_LEN = 123,
    parameter int RATE_DIV  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fir_sample_streamer_if.slave  bus
);

    import fir_stream_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int RC_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam int FC_W  = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RATE_DIV - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLUSH_LEN);

    state_t            state;
    logic [RC_W-1:0]   rate_cnt;
    logic [RC_W-1:0]   rate_next;
    logic [FC_W-1:0]   flush_cnt;
    logic              busy_q;
    logic              done_q;
    logic              valid_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  count_q;

    logic              tick;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_dout;

    assign tick      = (rate_cnt == '0);
    assign rate_next = (rate_cnt == RC_LAST) ? '0 : rate_cnt + 1'b1;
    assign pop       = (state == STREAM) && tick && !fifo_empty;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .pop   (pop),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rate_cnt   <= '0;
            flush_cnt  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;

            // A write against a full FIFO is lost even if a pop frees a slot
            // on the same edge, because the FIFO gates push with its old flag.
            if (bus.wr_en && fifo_full) begin
                overflow_q <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start && !fifo_empty) begin
                        state    <= STREAM;
                        busy_q   <= 1'b1;
                        rate_cnt <= '0;
                        count_q  <= '0;
                    end
                end

                STREAM: begin
                    rate_cnt <= rate_next;
                    if (tick) begin
                        if (!fifo_empty) begin
                            valid_q <= 1'b1;
                            count_q <= count_q + 1'b1;
                        end else if (FLUSH_LEN == 0) begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            state     <= FLUSH;
                            flush_cnt <= '0;
                        end
                    end
                end

                FLUSH: begin
                    // done follows the last zero by one cycle regardless of
                    // RATE_DIV, so it never overlaps valid_out.
                    if (flush_cnt == FC_LAST) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rate_cnt <= rate_next;
                        if (tick) begin
                            valid_q   <= 1'b1;
                            flush_cnt <= flush_cnt + 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full          = fifo_full;
    assign bus.overflow      = overflow_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.output_signal = fifo_dout;
    assign bus.valid_out     = valid_q;
    assign bus.sample_count  = count_q;

endmodule

// File: doc/fir_sample_streamer.md
# fir_sample_streamer

Sample source for the FIR datapath. A host loads a block of signed samples into an internal FIFO, then issues `start`. The block streams the samples to the filter as `output_signal`/`valid_out` at a programmable rate, then appends `FLUSH_LEN` zero samples to drain the filter's delay line and pulses `done`. It is the transmit side of the `input_signal`/`valid_in` interface that `fir_filter` consumes.

## Interface
- `DATA_W`, 16, sample width, two's complement
- `DEPTH`, 2048, FIFO depth in samples, power of two
- `FLUSH_LEN`, 123, zero samples appended after the data; equals filter taps − 1
- `RATE_DIV`, 1, cycles between emitted samples; 1 means every cycle; must be ≥1
- `clk  in  1  system clock; all logic on the rising edge`
- `rst  in  1  synchronous, active-high reset`
- `wr_en  in  1  host write strobe`
- `wr_data  in  DATA_W  signed sample to enqueue`
- `start  in  1  begin a run; level sampled each cycle`
- `full  out  1  FIFO holds DEPTH samples`
- `overflow  out  1  sticky: a write was dropped while full`
- `busy  out  1  state is not IDLE`
- `done  out  1  one-cycle pulse at the end of the flush`
- `output_signal  out  DATA_W  signed sample to filter; 0 when valid_out=0`
- `valid_out  out  1  output_signal is a valid sample this cycle`
- `sample_count  out  $clog2(DEPTH)+1  FIFO samples emitted in the current/last run`

## Operation
- FSM states: IDLE, STREAM, FLUSH.
- IDLE → STREAM: when `start`=1 and the FIFO is not empty. Otherwise `start` is ignored, including `start` while `busy`=1.
- Rate counter: resets to 0 on entry to STREAM. A tick occurs when the counter is 0; the counter wraps at `RATE_DIV`−1. The counter continues without reset across STREAM→FLUSH.
- STREAM, on a tick:
  - FIFO not empty: pop one sample, register it to `output_signal`, assert `valid_out`, and increment `sample_count`.
  - FIFO empty: go to FLUSH. No output is emitted on that tick.
  - Writes during STREAM are accepted, so they extend the run if they land before the FIFO drains.
- FLUSH: on each tick, emit `output_signal`=0 with `valid_out`=1. After the `FLUSH_LEN`-th zero, assert `done` for one cycle and return to IDLE.
  - If `FLUSH_LEN`=0, `done` is asserted on the tick that detects the FIFO empty.
- FIFO write rules:
  - `wr_en` with `full`=0: the write is accepted.
  - `wr_en` with `full`=1: the write is dropped and `overflow` sets, even if a pop occurs in the same cycle.
  - Simultaneous push and pop with the FIFO not full: count is unchanged.
- `sample_count` clears on IDLE→STREAM and holds its value after `done`.
- Data is passed through unmodified. There is no arithmetic on samples.
- `rst` at any time, including mid-run:
  - FSM → IDLE, FIFO emptied, rate counter cleared.
  - All outputs → 0: `full`, `overflow`, `busy`, `done`, `output_signal`, `valid_out`, `sample_count`.

## Timing
- All outputs are registered.
- `start` sampled at edge N → `busy`=1 after N. The first `valid_out` is high from edge N+1 to N+2.
- Later samples follow every `RATE_DIV` cycles. With `RATE_DIV`=1 and no underrun, `valid_out` is continuous for the data and the flush, except one idle cycle at the empty-detect tick.
- With `RATE_DIV`=R, `valid_out` lasts one cycle per tick and is low for the R−1 cycles between ticks.
- `done` rises one cycle after the last flush `valid_out` edge, so the two are never concurrent. `busy` falls together with `done`.
- Write at edge N → the sample is poppable from edge N+1.
- `full` and `overflow` update at the edge after the write.

## Structure
- Package `fir_stream_pkg` holds:
  - the `DATA_W` default;
  - the state enum (IDLE, STREAM, FLUSH);
  - a `sample_t` signed typedef, shared with `fir_filter`.
- One sub-module, `sync_fifo`:
  - parameterised width and depth;
  - ports `push`, `pop`, `din`, `dout`, `empty`, `full`, with a registered read.
- Streamer top holds the FSM, the rate counter, the flush counter and the output registers.

## Test plan
- Reset: hold `rst` for 2 cycles with `wr_en`/`start` toggling → every output reads 0 and `busy` stays 0.
- Basic run, `RATE_DIV`=1, `FLUSH_LEN`=3: write 5, −3, 32767, −32768, 0, then start → `valid_out` sequence 5, −3, 32767, −32768, 0, one idle cycle, 0, 0, 0 → `done` pulse, `sample_count`=5.
- Rate, `RATE_DIV`=4: write 3 samples and start → valid edges exactly 4 cycles apart, and `output_signal`=0 in the gaps.
- Overflow, `DEPTH`=4: write 6 samples → `full`=1 after the 4th write, `overflow`=1. The run emits only the first 4 samples.
- Start rules:
  - `start` with an empty FIFO → `busy` stays 0.
  - `start` pulsed during STREAM → the run proceeds unchanged and produces a single `done`.
- Reset mid-run: assert `rst` after 2 of 5 samples are emitted → next cycle `valid_out`=0, `busy`=0, FIFO empty. A fresh write of 1 sample plus `start` emits that sample, then the flush.
